// File: rtl/grn_pkg.sv
// grn_pkg: shared mode encoding, limits and next-state evaluation for GRN nodes
package grn_pkg;
  localparam int GRN_MAX_REG = 8;
  localparam int GRN_MAX_DIV = 16;
  localparam int GRN_SUM_W = $clog2(GRN_MAX_REG + 1) + 1;

  typedef enum logic [1:0] {
    GRN_AND  = 2'd0,
    GRN_OR   = 2'd1,
    GRN_THR  = 2'd2,
    GRN_HOLD = 2'd3
  } grn_mode_e;

  // Inputs are zero-extended to GRN_MAX_REG; only the low nreg positions take part.
  function automatic logic grn_eval(
    input logic [GRN_MAX_REG-1:0]      regs,
    input logic [GRN_MAX_REG-1:0]      mask,
    input grn_mode_e                   mode,
    input logic signed [GRN_SUM_W-1:0] thresh,
    input logic                        cur,
    input int                          nreg
  );
    logic all_on, any_on, eff;
    logic signed [GRN_SUM_W-1:0] score;
    all_on = 1'b1;
    any_on = 1'b0;
    score  = '0;
    for (int i = 0; i < GRN_MAX_REG; i++) begin
      if (i < nreg) begin
        eff    = mask[i] ? regs[i] : ~regs[i];
        all_on = all_on & eff;
        any_on = any_on | eff;
        if (regs[i]) score = mask[i] ? score + 5'sd1 : score - 5'sd1;
      end
    end
    return mode == GRN_AND ? all_on :
           mode == GRN_OR  ? any_on :
           mode == GRN_THR ? (score >= thresh) : cur;
  endfunction
endpackage

// File: rtl/grn_node_param_eval_unit.sv
// grn_eval_unit: combinational next-state function of one gene copy
module grn_eval_unit
  import grn_pkg::*;
#(
  parameter int NUM_REG  = 4,
  parameter     ACT_MASK = 4'b1111,
  parameter int MODE     = 0,
  parameter int THRESH   = 1
) (
  input  logic [NUM_REG-1:0] regs_i,
  input  logic               cur_i,
  output logic               nxt_o
);
  assign nxt_o = grn_eval(GRN_MAX_REG'(regs_i), GRN_MAX_REG'(ACT_MASK), grn_mode_e'(MODE),
                          GRN_SUM_W'(THRESH), cur_i, NUM_REG);
endmodule

// File: rtl/grn_node_param.sv
// grn_node_param: gene node with fast/slow state copies, match flag and change counter
module grn_node_param
  import grn_pkg::*;
#(
  parameter int NUM_REG  = 4,
  parameter     ACT_MASK = 4'b1111,
  parameter int MODE     = 0,
  parameter int THRESH   = 1,
  parameter int SLOW_DIV = 2,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               reset_nos,
  input  logic               init_state,
  input  logic               start_s0,
  input  logic               start_s1,
  input  logic [NUM_REG-1:0] reg_s0,
  input  logic [NUM_REG-1:0] reg_s1,
  output logic               s0,
  output logic               s1,
  output logic               match,
  output logic [CNT_W-1:0]   chg_cnt
);
  localparam int DIV_W = SLOW_DIV > 1 ? $clog2(SLOW_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_DIV - 1);

  if (NUM_REG < 1 || NUM_REG > GRN_MAX_REG) begin : g_bad_num_reg
    $error("grn_node_param: NUM_REG out of range 1..8");
  end
  if (SLOW_DIV < 1 || SLOW_DIV > GRN_MAX_DIV) begin : g_bad_slow_div
    $error("grn_node_param: SLOW_DIV out of range 1..16");
  end
  if (THRESH < -NUM_REG || THRESH > NUM_REG) begin : g_bad_thresh
    $error("grn_node_param: THRESH out of range -NUM_REG..NUM_REG");
  end
  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("grn_node_param: MODE out of range 0..3");
  end
  if ($bits(ACT_MASK) != NUM_REG) begin : g_bad_mask
    $error("grn_node_param: ACT_MASK width must equal NUM_REG");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("grn_node_param: CNT_W must be at least 1");
  end

  logic s0_q, s0_d, s1_q, s1_d, match_q, f0, f1;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  grn_eval_unit #(.NUM_REG(NUM_REG), .ACT_MASK(ACT_MASK), .MODE(MODE), .THRESH(THRESH))
    u_eval_s0 (.regs_i(reg_s0), .cur_i(s0_q), .nxt_o(f0));
  grn_eval_unit #(.NUM_REG(NUM_REG), .ACT_MASK(ACT_MASK), .MODE(MODE), .THRESH(THRESH))
    u_eval_s1 (.regs_i(reg_s1), .cur_i(s1_q), .nxt_o(f1));

  // next state: re-initialise beats strobes; slow copy steps only when the divider wraps
  always_comb begin
    s0_d  = reset_nos ? init_state : (start_s0 && div_q == DIV_LAST) ? f0 : s0_q;
    s1_d  = reset_nos ? init_state : start_s1 ? f1 : s1_q;
    div_d = reset_nos ? DIV_LAST : !start_s0 ? div_q : div_q == DIV_LAST ? '0 : div_q + 1'b1;
    cnt_d = reset_nos ? '0 : (start_s1 && f1 != s1_q && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end

  // state registers; match is taken from next-state values so it tracks the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      match_q <= 1'b1;
      div_q   <= '0;
      cnt_q   <= '0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      match_q <= s0_d == s1_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s0      = s0_q;
  assign s1      = s1_q;
  assign match   = match_q;
  assign chg_cnt = cnt_q;
endmodule

// File: doc/grn_node_param.md
# grn_node_param

Parametrised gene-regulatory-network node for the GRN accelerator's network-simulation array. It holds two copies of one Boolean gene state: a fast copy `s1` that updates on every `start_s1`, and a slow copy `s0` that updates once per `SLOW_DIV` `start_s0` pulses, for cycle/attractor detection. The next state is computed from `NUM_REG` regulator inputs, each marked activator or inhibitor, under a selectable combining mode. It replaces the per-gene fixed-function node modules, and adds a saturating change counter on the fast copy.

## Interface
Parameters:
- `NUM_REG`, 4, number of regulator inputs; legal range 1..8.
- `ACT_MASK`, 4'b1111, per-input polarity: bit i = 1 means activator, 0 means inhibitor.
- `MODE`, 0, combining function: 0 = AND, 1 = OR, 2 = THRESHOLD, 3 = HOLD.
- `THRESH`, 1, signed threshold for MODE 2; range -NUM_REG..NUM_REG.
- `SLOW_DIV`, 2, `start_s0` pulses per slow-copy update; legal range 1..16.
- `CNT_W`, 16, width of the change counter.

Ports:
- `clk`, in, 1, clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `reset_nos`, in, 1, synchronous network re-initialise.
- `init_state`, in, 1, value loaded into both copies on `reset_nos`.
- `start_s0`, in, 1, slow-copy step strobe.
- `start_s1`, in, 1, fast-copy step strobe.
- `reg_s0`, in, NUM_REG, regulator states, slow trajectory.
- `reg_s1`, in, NUM_REG, regulator states, fast trajectory.
- `s0`, out, 1, slow-copy state (registered).
- `s1`, out, 1, fast-copy state (registered).
- `match`, out, 1, registered `s0 == s1`.
- `chg_cnt`, out, CNT_W, number of `s1` value changes since the last `reset_nos`; saturating.

## Operation
- Effective input: eff[i] = reg[i] when ACT_MASK[i] = 1, otherwise ~reg[i].
- Next-state function f(reg, cur):
  - AND: all eff bits are 1.
  - OR: any eff bit is 1.
  - THRESHOLD: (count of active activators − count of active inhibitors) >= THRESH. Evaluate in signed arithmetic, width $clog2(NUM_REG+1)+1.
  - HOLD: f = cur; the state never changes.
- Fast copy: on `start_s1`, `s1` <= f(reg_s1, s1).
- Slow copy uses a divider counter `div` of width $clog2(SLOW_DIV).
  - On `start_s0` with div == SLOW_DIV−1: `s0` <= f(reg_s0, s0) and `div` <= 0.
  - On `start_s0` otherwise: `div` increments and `s0` holds.
  - With SLOW_DIV = 1, every `start_s0` updates `s0`.
- `reset_nos`:
  - `s0` and `s1` <= `init_state`.
  - `div` <= SLOW_DIV−1, so the first `start_s0` after `reset_nos` updates.
  - `chg_cnt` <= 0.
- `chg_cnt` increments when an `s1` update changes its value, and stays at 2^CNT_W−1 once there.
- `match` is registered from the next-state values of `s0` and `s1`, so it reflects the current outputs.
- Priority: `rst_n` > `reset_nos` > `start_s0` / `start_s1`.
  - `start_s0` and `start_s1` are independent; both may be asserted in the same cycle.
  - A start strobe in the same cycle as `reset_nos` is ignored.

## Timing
- Asynchronous reset sets `s0` = 0, `s1` = 0, `match` = 1, `chg_cnt` = 0 and `div` = 0.
  - Note: `div` is 0 after `rst_n`, unlike after `reset_nos`. The first slow update after `rst_n` therefore happens on the SLOW_DIV-th `start_s0`.
- Deassertion of `rst_n` is synchronised by the parent; the block sees it clean.
- Latency: one cycle from a strobe edge to the new `s0`/`s1`. `match` and `chg_cnt` update in that same edge.
- Regulator inputs are sampled only on the clock edge where the corresponding strobe is high; they are don't-care otherwise.
- No back-pressure. A strobe is accepted every cycle it is high, including back-to-back cycles.
- `rst_n` asserted mid-sequence discards the divider phase and the counter immediately.

## Structure
- Shared package `grn_pkg`:
  - Mode constants `GRN_AND`, `GRN_OR`, `GRN_THR`, `GRN_HOLD`.
  - Function `grn_eval(reg, mask, mode, thresh, cur)`.
  - Limits `GRN_MAX_REG` = 8 and `GRN_MAX_DIV` = 16.
- One sub-module, `grn_eval_unit`: purely combinational evaluation of f. It is instantiated twice, once for the slow copy and once for the fast copy.
- Elaboration-time checks: parameter ranges, and that ACT_MASK width equals NUM_REG.

## Test plan
- Reset: with `rst_n` = 0, outputs are s0 = 0, s1 = 0, match = 1, chg_cnt = 0. Release, hold `reset_nos` one cycle with init_state = 1 → s0 = s1 = 1, match = 1, chg_cnt = 0.
- AND mode, NUM_REG = 4, ACT_MASK = 4'b0011:
  - reg_s1 = 4'b0011 with start_s1 → s1 = 1.
  - reg_s1 = 4'b0111 with start_s1 → s1 = 0 and chg_cnt increments by 1.
- THRESHOLD, THRESH = 1, ACT_MASK = 4'b0111:
  - reg_s1 = 4'b1011 → 2 − 1 = 1 ≥ 1, so s1 = 1.
  - reg_s1 = 4'b1001 → 1 − 1 = 0, so s1 = 0.
- SLOW_DIV = 3, `reset_nos`, then 7 consecutive `start_s0` with f = ~init → s0 updates on pulses 1, 4 and 7 only. Check `match` against `s1` after each pulse.
- Collisions:
  - `reset_nos` together with `start_s0` and `start_s1` → both copies = init_state and the strobes are ignored.
  - `start_s0` and `start_s1` in the same cycle → both copies update.
- HOLD mode with 100 strobes on each input → state unchanged, chg_cnt = 0.
- CNT_W = 2 with 5 toggling `s1` updates → chg_cnt saturates at 3.
